// File: rtl/gf180mcu_osu_sc_12t_clkdiv_gate.sv
// gf180mcu_osu_sc_12t_clkdiv_gate: glitch-free programmable integer clock divider/gate with boundary-synchronised ratio loads
module gf180mcu_osu_sc_12t_clkdiv_gate #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIV,
  output logic             Y,
  output logic             BUSY,
  output logic             ACT
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t r_state, w_state;
  logic [WIDTH-1:0] r_cnt, r_cur, r_pend, w_cnt, w_cur, w_pend, w_h, w_l, w_div;
  logic r_y, r_busy, r_act, w_busy, w_hi_end, w_lo_end, w_ld_run;
  assign w_h = (r_cur >> 1) + {{(WIDTH-1){1'b0}}, r_cur[0]};
  assign w_l = r_cur >> 1;
  assign w_div = DIV < WIDTH'(2) ? WIDTH'(2) : DIV;
  assign w_hi_end = r_state == HIGH && r_cnt == w_h - WIDTH'(1);
  assign w_lo_end = r_state == LOW && r_cnt == w_l - WIDTH'(1);
  assign w_ld_run = LD && r_state != IDLE;
  // a pending ratio lands at every period end, whether the divider wraps or stops
  always_comb begin
    w_state = r_state == IDLE ? (EN ? HIGH : IDLE) :
              w_hi_end ? LOW : w_lo_end ? (EN ? HIGH : IDLE) : r_state;
    w_cnt = (r_state == IDLE || w_hi_end || w_lo_end) ? '0 : r_cnt + WIDTH'(1);
    w_cur = (LD && r_state == IDLE) ? w_div : (w_lo_end && r_busy) ? r_pend : r_cur;
    w_pend = w_ld_run ? w_div : r_pend;
    w_busy = w_ld_run || (r_busy && !w_lo_end);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_cur <= WIDTH'(2);
      r_pend <= WIDTH'(2);
      r_y <= 1'b0;
      r_busy <= 1'b0;
      r_act <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_cur <= w_cur;
      r_pend <= w_pend;
      r_y <= w_state == HIGH;
      r_busy <= w_busy;
      r_act <= w_state != IDLE;
    end
  end
  assign Y = r_y;
  assign BUSY = r_busy;
  assign ACT = r_act;
endmodule
